regfile_dump: RTL and testbench

Debug readback sequencer for the 16x16 register file. When `start` is pulsed, it walks the register file's read port through every register in order. Each captured word is streamed out, together with its register number, on a valid/ready output channel. It is the reading counterpart to the register write path. It sits beside the register file and shares one read port, muxed in by the debug controller while `busy` is high.

---
 rtl/regfile_dump.sv | 95 +++++++++
 tb/tb_regfile_dump.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - register file debug readback sequencer; optional REGFILE_DUMP_SKIP_R0_EN skips R0
module regfile_dump #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
`ifdef REGFILE_DUMP_SKIP_R0_EN
    // R0 reads as constant zero, so there is nothing worth dumping there
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] FIRST_IDX = '0;
`endif

    state_t            state;
    logic [ADDR_W-1:0] idx;

    // The read port follows idx directly; idx is parked at 0 while idle
    assign rf_raddr = idx;

    // Sequencer: all outputs registered alongside the state transition
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        idx   <= FIRST_IDX;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state     <= S_SEND;
                    out_data  <= rf_rdata;
                    out_addr  <= idx;
                    out_valid <= 1'b1;
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                            idx   <= idx + ADDR_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= '0;
                end
                default: begin
                    state     <= S_IDLE;
                    idx       <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - directed self-checking bench for regfile_dump
module tb_regfile_dump;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_addr;

`ifdef REGFILE_DUMP_SKIP_R0_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam int NB = 16 - FIRST;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    int e0       = 0;
    int exp_addr = 0;
    int beats    = 0;
    int dones    = 0;
    bit chk_t    = 1'b1;

    regfile_dump dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_addr (out_addr)
    );

    // Register file model: Rn = 0x1000 + n
    assign rf_rdata = 16'h1000 + 16'(rf_raddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Beat scoreboard: a handshake seen at the negedge completes at the next posedge
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            check("beat_addr", 32'(out_addr), 32'(exp_addr));
            check("beat_data", 32'(out_data), 32'h1000 + 32'(exp_addr));
            check("beat_raddr", 32'(rf_raddr), 32'(exp_addr));
            if (chk_t) check("beat_edge", 32'(edge_cnt + 1), 32'(e0 + 2 + 2 * beats));
            exp_addr++;
            beats++;
        end
        if (rst && done) begin
            if (chk_t) check("done_edge", 32'(edge_cnt), 32'(e0 + 2 * NB));
            dones++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump();
        exp_addr = FIRST;
        beats    = 0;
        dones    = 0;
        start    = 1'b1;
        e0       = edge_cnt + 1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_addr(input int a);
        int n;
        n = 0;
        while (!(out_valid && int'(out_addr) == a) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("wait_addr_timeout", 32'(n), 32'(0));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (dones == 0 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check({tag, "_timeout"}, 32'(n), 32'(0));
        step();
        step();
        step();
        check({tag, "_beats"}, 32'(beats), 32'(NB));
        check({tag, "_dones"}, 32'(dones), 32'(1));
        check({tag, "_busy_end"}, 32'(busy), 32'(0));
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;

        // 1: reset values
        step();
        step();
        rst = 1'b1;
        step();
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_data", 32'(out_data), 32'(0));
        check("rst_addr", 32'(out_addr), 32'(0));
        check("rst_raddr", 32'(rf_raddr), 32'(0));

        // 2: full dump with out_ready held high
        start_dump();
        check("busy_after_start", 32'(busy), 32'(1));
        check("valid_in_load", 32'(out_valid), 32'(0));
        step();
        check("first_valid", 32'(out_valid), 32'(1));
        wait_done("full");

        // 3: backpressure on beat 5
        chk_t = 1'b0;
        start_dump();
        wait_addr(5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_valid", 32'(out_valid), 32'(1));
            check("bp_data", 32'(out_data), 32'h1005);
            check("bp_addr", 32'(out_addr), 32'(5));
        end
        out_ready = 1'b1;
        wait_done("bp");

        // 4: start while busy is ignored
        chk_t = 1'b1;
        start_dump();
        wait_addr(3);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_addr(9);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("restart");

        // 5: asynchronous reset mid-dump
        start_dump();
        wait_addr(7);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_data", 32'(out_data), 32'(0));
        check("mid_rst_addr", 32'(out_addr), 32'(0));
        check("mid_rst_raddr", 32'(rf_raddr), 32'(0));
        step();
        step();
        check("mid_rst_no_done", 32'(dones), 32'(0));
        rst = 1'b1;
        step();
        start_dump();
        wait_done("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
